speed_level_ctrl: RTL



---
 rtl/speed_level_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/speed_level_ctrl.sv
// Speed-level controller: button edges -> target/applied level, PWM compare and BCD percent.
// Optional slew-limited ramp toward the target when SPEED_RAMP_EN is defined.
module speed_level_ctrl #(
    parameter int LEVELS   = 7,
    parameter int CV_W     = 4,
    parameter int CV_STEP  = 2,
    parameter int PCT_STEP = 15,
    parameter int RAMP_DIV = 1000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_u,
    input  logic            i_d,
    input  logic            i_stop,
    output logic [3:0]      o_target,
    output logic [3:0]      o_level,
    output logic [CV_W-1:0] o_cv,
    output logic [3:0]      o_left_digit,
    output logic [3:0]      o_right_digit,
    output logic            o_at_target
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DN
    } state_t;

    localparam logic [3:0] TOP = 4'(LEVELS - 1);
    localparam int PW = CV_W + 8;
    localparam logic [PW-1:0] CV_MAX = PW'((1 << CV_W) - 1);

    state_t     state;
    logic       u_q;
    logic       d_q;
    logic       up_ev;
    logic       dn_ev;
    logic [PW-1:0] prod;
    logic [7:0] pct;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            u_q <= 1'b0;
            d_q <= 1'b0;
        end else begin
            u_q <= i_u;
            d_q <= i_d;
        end
    end

    // Simultaneous buttons cancel each other out
    assign up_ev = i_u & ~u_q & ~i_d;
    assign dn_ev = i_d & ~d_q & ~i_u;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_stop) begin
            o_target <= 4'd0;
        end else if (up_ev && o_target != TOP) begin
            o_target <= o_target + 4'd1;
        end else if (dn_ev && o_target != 4'd0) begin
            o_target <= o_target - 4'd1;
        end
    end

    always_comb begin
        state = IDLE;
        if (o_level < o_target) begin
            state = RAMP_UP;
        end else if (o_level > o_target) begin
            state = RAMP_DN;
        end
    end

    assign o_at_target = (state == IDLE);

`ifdef SPEED_RAMP_EN
    localparam int CW = $clog2(RAMP_DIV);

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc = (cnt == CW'(RAMP_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || i_stop) begin
            cnt     <= '0;
            o_level <= 4'd0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (tc) begin
            cnt     <= '0;
            o_level <= (state == RAMP_UP) ? o_level + 4'd1
                                          : o_level - 4'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stop) begin
            o_level <= 4'd0;
        end else begin
            o_level <= o_target;
        end
    end
`endif

    always_comb begin
        prod = PW'(o_level) * PW'(CV_STEP);
        pct  = 8'(o_level) * 8'(PCT_STEP);
        o_cv = (prod > CV_MAX) ? CV_W'(CV_MAX) : CV_W'(prod);
        o_left_digit  = 4'(pct / 8'd10);
        o_right_digit = 4'(pct % 8'd10);
    end

endmodule
